// File: rtl/mutex.sv
`default_nettype none
// ============================================================================
// Module   : mutex
// Purpose  : Registered sign classifier with mutually exclusive pos/neg flags.
//            Optional zero_flag output when MUTEX_ZERO_FLAG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mutex #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic             positive_flag,
`ifdef MUTEX_ZERO_FLAG_EN
  output logic             zero_flag,
`endif
  output logic             negative_flag
);

  logic positive_d, positive_q;
  logic negative_d, negative_q;

  // Sign bit alone decides negative; positive needs a clear sign bit and a nonzero magnitude.
  always_comb begin
    negative_d = in[WIDTH-1];
    positive_d = ~in[WIDTH-1] & (|in[WIDTH-2:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      positive_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      positive_q <= positive_d;
      negative_q <= negative_d;
    end
  end

  assign positive_flag = positive_q;
  assign negative_flag = negative_q;

`ifdef MUTEX_ZERO_FLAG_EN
  logic zero_d, zero_q;

  always_comb begin
    zero_d = ~(|in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_flag = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mutex.sv
`default_nettype none
// ============================================================================
// Module   : tb_mutex
// Purpose  : Self-checking bench for mutex against a signed-value reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mutex;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic             pos;
  logic             neg;
`ifdef MUTEX_ZERO_FLAG_EN
  logic             zro;
`endif

  int n_checks = 0;
  int n_err    = 0;

  mutex #(.WIDTH(WIDTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in            (din),
    .positive_flag (pos),
`ifdef MUTEX_ZERO_FLAG_EN
    .zero_flag     (zro),
`endif
    .negative_flag (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: classify the word as a signed integer.
  task automatic check_flags(input string tag, input logic [WIDTH-1:0] v);
    int s;
    s = $signed(v);
    chk({tag, ".pos"}, {31'd0, pos}, (s > 0) ? 32'd1 : 32'd0);
    chk({tag, ".neg"}, {31'd0, neg}, (s < 0) ? 32'd1 : 32'd0);
    chk({tag, ".excl"}, {31'd0, pos & neg}, 32'd0);
`ifdef MUTEX_ZERO_FLAG_EN
    chk({tag, ".zero"}, {31'd0, zro}, (s == 0) ? 32'd1 : 32'd0);
`endif
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, ".pos"}, {31'd0, pos}, 32'd0);
    chk({tag, ".neg"}, {31'd0, neg}, 32'd0);
`ifdef MUTEX_ZERO_FLAG_EN
    chk({tag, ".zero"}, {31'd0, zro}, 32'd0);
`endif
  endtask

  // Present v at a rising edge, then scramble the input so a combinational
  // leak from in to the flags would show up in the check that follows.
  task automatic apply(input string tag, input logic [WIDTH-1:0] v);
    @(negedge clk);
    din = v;
    @(posedge clk);
    #1 din = ~v;
    #1 check_flags(tag, v);
  endtask

  logic [WIDTH-1:0] seq [4];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] nxt;

  initial begin
    rst_n = 1'b0;
    din   = 16'd10;

    // Reset held across several edges with a positive word present.
    repeat (4) begin
      @(posedge clk);
      #1 check_cleared("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    apply("pos10", 16'd10);
    // Asynchronous reset between edges.
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_cleared("rst_async");
    #1 rst_n = 1'b1;

    apply("neg5", 16'hFFFB);
    apply("zero", 16'd0);
    apply("maxpos", 16'h7FFF);
    apply("maxneg", 16'h8000);
    apply("one", 16'd1);
    apply("minus1", 16'hFFFF);

    seq[0] = 16'd12345;
    seq[1] = 16'(-12345);
    seq[2] = 16'd0;
    seq[3] = 16'd12345;
    for (int i = 0; i < 4; i++) apply("b2b", seq[i]);

    // Reset pulse while -12345 is waiting to be sampled.
    apply("pre_pulse", 16'd12345);
    @(negedge clk);
    din = 16'(-12345);
    #1 rst_n = 1'b0;
    #1 check_cleared("rst_pulse");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 check_flags("post_pulse", 16'(-12345));

    // Random stream, input changing every cycle just after each edge.
    prev = din;
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 7))
        0:       nxt = 16'd0;
        1:       nxt = 16'h8000;
        2:       nxt = 16'h7FFF;
        3:       nxt = 16'hFFFF;
        4:       nxt = 16'd1;
        default: nxt = 16'($urandom);
      endcase
      @(posedge clk);
      #1 din = nxt;
      #1 check_flags("rand", prev);
      prev = nxt;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
